// File: rtl/sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
//   Single-clock FIFO used between pipeline stages of the core.  Storage is
//   an internal register array of DEPTH = 2**ADDR_WIDTH words.  Occupancy is
//   tracked with an ADDR_WIDTH+1 bit counter, so a completely full FIFO is
//   distinguished from an empty one without wasting an entry.
//
//   Read modes (parameter FWFT):
//     0 : standard registered read.  A pop loads rd_data one cycle later and
//         pulses rd_valid for that cycle.  rd_data otherwise holds.
//     1 : first-word-fall-through.  rd_data always shows the oldest word,
//         rd_valid = !empty, rd_en acknowledges/pops the shown word.
//
//   Optional build macro SYNC_FIFO_ERR_EN adds sticky overflow/underflow
//   flags cleared by rst or err_clr.  Without it those outputs are tied low
//   and err_clr is ignored.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   wr_en        in   write request (accepted when not full)
//   wr_data      in   write data [DATA_WIDTH]
//   rd_en        in   read request / FWFT acknowledge (accepted when not empty)
//   rd_data      out  read data [DATA_WIDTH]
//   rd_valid     out  standard: newly popped word present; FWFT: !empty
//   full         out  level == DEPTH
//   empty        out  level == 0
//   almost_full  out  level >= AFULL_THRESH
//   almost_empty out  level <= AEMPTY_THRESH
//   level        out  occupancy 0..DEPTH [ADDR_WIDTH+1]
//   overflow     out  sticky: write attempted while full (SYNC_FIFO_ERR_EN)
//   underflow    out  sticky: read attempted while empty (SYNC_FIFO_ERR_EN)
//   err_clr      in   clears overflow/underflow (SYNC_FIFO_ERR_EN)
// -----------------------------------------------------------------------------
module sync_fifo_fwft #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 3,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   DEPTH_LVL  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   AFULL_LVL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   AEMPTY_LVL = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

    // Elaboration-time threshold legality check.
    sync_fifo_fwft_param_chk #(
        .DEPTH         (DEPTH),
        .AFULL_THRESH  (AFULL_THRESH),
        .AEMPTY_THRESH (AEMPTY_THRESH)
    ) u_param_chk ();

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_WIDTH-1:0] head_r;
    logic [ADDR_WIDTH-1:0] tail_r;
    logic [ADDR_WIDTH:0]   level_r;
    logic                  full_r;
    logic                  empty_r;
    logic                  afull_r;
    logic                  aempty_r;

    logic                  push_s;
    logic                  pop_s;
    logic [ADDR_WIDTH:0]   level_nxt_s;
    logic                  full_nxt_s;
    logic                  empty_nxt_s;
    logic                  afull_nxt_s;
    logic                  aempty_nxt_s;

    // Transfers are qualified by the flags registered at the start of the
    // cycle, so a full FIFO never writes through and an empty one never
    // bypasses.
    always_comb begin
        push_s       = wr_en && !full_r;
        pop_s        = rd_en && !empty_r;
        level_nxt_s  = level_r + {{ADDR_WIDTH{1'b0}}, push_s}
                               - {{ADDR_WIDTH{1'b0}}, pop_s};
        full_nxt_s   = (level_nxt_s == DEPTH_LVL);
        empty_nxt_s  = (level_nxt_s == {(ADDR_WIDTH+1){1'b0}});
        afull_nxt_s  = (level_nxt_s >= AFULL_LVL);
        aempty_nxt_s = (level_nxt_s <= AEMPTY_LVL);
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_r[head_r] <= wr_data;
        end
    end

    // Pointers, occupancy and status flags.  Flags are registered from the
    // next level so they line up with level itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r   <= {ADDR_WIDTH{1'b0}};
            tail_r   <= {ADDR_WIDTH{1'b0}};
            level_r  <= {(ADDR_WIDTH+1){1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= 1'b0;
            aempty_r <= 1'b1;
        end else begin
            if (push_s) begin
                head_r <= head_r + PTR_ONE;
            end
            if (pop_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            level_r  <= level_nxt_s;
            full_r   <= full_nxt_s;
            empty_r  <= empty_nxt_s;
            afull_r  <= afull_nxt_s;
            aempty_r <= aempty_nxt_s;
        end
    end

    assign level        = level_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = afull_r;
    assign almost_empty = aempty_r;

    generate
        if (FWFT != 0) begin : g_fwft
            // Oldest word is always visible; rd_en only advances the tail.
            assign rd_data  = mem_r[tail_r];
            assign rd_valid = !empty_r;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_r;
            logic                  rd_valid_r;

            // Registered read port: one-cycle latency, data holds between pops.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_r  <= {DATA_WIDTH{1'b0}};
                    rd_valid_r <= 1'b0;
                end else if (pop_s) begin
                    rd_data_r  <= mem_r[tail_r];
                    rd_valid_r <= 1'b1;
                end else begin
                    rd_valid_r <= 1'b0;
                end
            end

            assign rd_data  = rd_data_r;
            assign rd_valid = rd_valid_r;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_r;
    logic underflow_r;

    // Sticky error flags; err_clr wins over a set in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (err_clr) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_en && full_r) begin
                overflow_r <= 1'b1;
            end
            if (rd_en && empty_r) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_r;
    assign underflow = underflow_r;
`else
    logic err_clr_unused_s;

    assign err_clr_unused_s = err_clr;
    assign overflow         = 1'b0;
    assign underflow        = 1'b0;
`endif

endmodule

// -----------------------------------------------------------------------------
// sync_fifo_fwft_param_chk
//   Elaboration-only checker for the FIFO threshold parameters.
//   Legal: 1 <= AFULL_THRESH <= DEPTH and 0 <= AEMPTY_THRESH < DEPTH.
//   No ports.
// -----------------------------------------------------------------------------
module sync_fifo_fwft_param_chk #(
    parameter int DEPTH         = 8,
    parameter int AFULL_THRESH  = 7,
    parameter int AEMPTY_THRESH = 1
) ();

    generate
        if ((AFULL_THRESH < 1) || (AFULL_THRESH > DEPTH) ||
            (AEMPTY_THRESH < 0) || (AEMPTY_THRESH >= DEPTH)) begin : g_bad_thresh
            $error("sync_fifo_fwft: illegal AFULL_THRESH/AEMPTY_THRESH for DEPTH");
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_fwft
//   Directed self-checking bench.  Two instances share one stimulus stream:
//   dut_s (standard read, FWFT=0) and dut_f (first-word-fall-through, FWFT=1),
//   both DATA_WIDTH=8, ADDR_WIDTH=3.  Inputs change 1 ns after the rising
//   edge and outputs are sampled there too, away from the active edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo_fwft;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic       err_clr;

    logic [7:0] s_rd_data, f_rd_data;
    logic       s_rd_valid, f_rd_valid;
    logic       s_full, f_full, s_empty, f_empty;
    logic       s_afull, f_afull, s_aempty, f_aempty;
    logic [3:0] s_level, f_level;
    logic       s_ovf, f_ovf, s_unf, f_unf;

    int checks = 0;
    int errors = 0;

`ifdef SYNC_FIFO_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    sync_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(0)) dut_s (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_afull), .almost_empty(s_aempty), .level(s_level),
        .overflow(s_ovf), .underflow(s_unf), .err_clr(err_clr)
    );

    sync_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1)) dut_f (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_afull), .almost_empty(f_aempty), .level(f_level),
        .overflow(f_ovf), .underflow(f_unf), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); wr_data = 8'h00;
        tick(); tick();
        rst = 1'b0;
        checks++; if (s_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", s_level); end
        checks++; if ({s_empty, s_full, s_afull, s_aempty} !== 4'b1001) begin errors++; $display("FAIL reset_flags: got %b expected 1001", {s_empty, s_full, s_afull, s_aempty}); end
        checks++; if ({s_rd_valid, s_rd_data} !== 9'h000) begin errors++; $display("FAIL reset_rd: got valid=%b data=%h expected 0/00", s_rd_valid, s_rd_data); end
        checks++; if ({s_ovf, s_unf, f_rd_valid, f_empty} !== 4'b0001) begin errors++; $display("FAIL reset_misc: got %b expected 0001", {s_ovf, s_unf, f_rd_valid, f_empty}); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            checks++; if (s_level !== 4'(i)) begin errors++; $display("FAIL fill_level[%0d]: got %0d expected %0d", i, s_level, i); end
            checks++; if ({s_full, s_afull, s_aempty, s_empty} !== {(i == 8), (i >= 7), (i <= 1), 1'b0}) begin
                errors++; $display("FAIL fill_flags[%0d]: got %b expected %b", i, {s_full, s_afull, s_aempty, s_empty}, {(i == 8), (i >= 7), (i <= 1), 1'b0});
            end
        end
        wr_en = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (f_rd_data !== 8'(i)) begin errors++; $display("FAIL fwft_show[%0d]: got %h expected %h", i, f_rd_data, 8'(i)); end
            rd_en = 1'b1;
            tick();
            checks++; if ({s_rd_valid, s_rd_data} !== {1'b1, 8'(i)}) begin errors++; $display("FAIL drain_rd[%0d]: got valid=%b data=%h expected 1/%h", i, s_rd_valid, s_rd_data, 8'(i)); end
            checks++; if (s_level !== 4'(8 - i)) begin errors++; $display("FAIL drain_level[%0d]: got %0d expected %0d", i, s_level, 8 - i); end
        end
        rd_en = 1'b0;
        tick();
        checks++; if ({s_rd_valid, s_rd_data, s_empty} !== {1'b0, 8'h08, 1'b1}) begin errors++; $display("FAIL drain_end: got valid=%b data=%h empty=%b expected 0/08/1", s_rd_valid, s_rd_data, s_empty); end
    endtask

    task automatic test_full_rw();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            tick();
        end
        wr_data = 8'hEE; rd_en = 1'b1;
        tick();
        idle();
        checks++; if (s_level !== 4'd7) begin errors++; $display("FAIL full_rw_level: got %0d expected 7", s_level); end
        checks++; if ({s_rd_valid, s_rd_data, s_full} !== {1'b1, 8'h10, 1'b0}) begin errors++; $display("FAIL full_rw_rd: got valid=%b data=%h full=%b expected 1/10/0", s_rd_valid, s_rd_data, s_full); end
        checks++; if (s_ovf !== ERR_ON) begin errors++; $display("FAIL overflow_set: got %b expected %b", s_ovf, ERR_ON); end
        tick();
        checks++; if (s_ovf !== ERR_ON) begin errors++; $display("FAIL overflow_sticky: got %b expected %b", s_ovf, ERR_ON); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL overflow_clr: got %b expected 0", s_ovf); end
        for (int i = 1; i <= 7; i++) begin
            rd_en = 1'b1;
            tick();
            checks++; if (s_rd_data !== 8'(8'h10 + i)) begin errors++; $display("FAIL full_rw_drain[%0d]: got %h expected %h", i, s_rd_data, 8'(8'h10 + i)); end
        end
        rd_en = 1'b0;
        tick();
        checks++; if ({s_empty, s_level} !== {1'b1, 4'd0}) begin errors++; $display("FAIL full_rw_empty: got empty=%b level=%0d expected 1/0", s_empty, s_level); end
    endtask

    task automatic test_empty_rd();
        rd_en = 1'b1;
        tick();
        checks++; if ({s_level, s_rd_valid} !== {4'd0, 1'b0}) begin errors++; $display("FAIL empty_rd: got level=%0d valid=%b expected 0/0", s_level, s_rd_valid); end
        checks++; if (s_unf !== ERR_ON) begin errors++; $display("FAIL underflow_set: got %b expected %b", s_unf, ERR_ON); end
        wr_en = 1'b1; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        checks++; if ({s_level, s_rd_valid, s_empty} !== {4'd1, 1'b0, 1'b0}) begin errors++; $display("FAIL empty_wr_rd: got level=%0d valid=%b empty=%b expected 1/0/0", s_level, s_rd_valid, s_empty); end
        tick();
        rd_en = 1'b0;
        checks++; if ({s_rd_valid, s_rd_data, s_level} !== {1'b1, 8'hA5, 4'd0}) begin errors++; $display("FAIL empty_then_pop: got valid=%b data=%h level=%0d expected 1/a5/0", s_rd_valid, s_rd_data, s_level); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (s_unf !== 1'b0) begin errors++; $display("FAIL underflow_clr: got %b expected 0", s_unf); end
    endtask

    task automatic test_fwft();
        wr_en = 1'b1; wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        checks++; if ({f_empty, f_rd_valid, f_rd_data} !== {1'b0, 1'b1, 8'h3C}) begin errors++; $display("FAIL fwft_show: got empty=%b valid=%b data=%h expected 0/1/3c", f_empty, f_rd_valid, f_rd_data); end
        checks++; if (s_rd_valid !== 1'b0) begin errors++; $display("FAIL std_no_autoread: got %b expected 0", s_rd_valid); end
        tick();
        checks++; if ({f_rd_valid, f_rd_data} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL fwft_hold: got valid=%b data=%h expected 1/3c", f_rd_valid, f_rd_data); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if ({f_empty, f_rd_valid} !== 2'b10) begin errors++; $display("FAIL fwft_pop: got empty=%b valid=%b expected 1/0", f_empty, f_rd_valid); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i);
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            checks++; if (f_rd_data !== 8'(8'h40 + k)) begin errors++; $display("FAIL wrap_fwft[%0d]: got %h expected %h", k, f_rd_data, 8'(8'h40 + k)); end
            wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h43 + k);
            tick();
            checks++; if ({s_rd_data, s_level} !== {8'(8'h40 + k), 4'd3}) begin errors++; $display("FAIL wrap[%0d]: got data=%h level=%0d expected %h/3", k, s_rd_data, s_level, 8'(8'h40 + k)); end
        end
        wr_en = 1'b0;
        for (int k = 20; k < 23; k++) begin
            tick();
            checks++; if (s_rd_data !== 8'(8'h40 + k)) begin errors++; $display("FAIL wrap_tail[%0d]: got %h expected %h", k, s_rd_data, 8'(8'h40 + k)); end
        end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h50 + i);
            tick();
        end
        wr_en = 1'b0;
        checks++; if (s_level !== 4'd5) begin errors++; $display("FAIL pre_reset_level: got %0d expected 5", s_level); end
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hFF;
        tick();
        rst = 1'b0; idle();
        checks++; if ({s_level, s_empty, s_full, s_afull, s_aempty} !== {4'd0, 4'b1001}) begin errors++; $display("FAIL mid_reset_state: got level=%0d flags=%b expected 0/1001", s_level, {s_empty, s_full, s_afull, s_aempty}); end
        checks++; if ({s_rd_valid, s_rd_data, f_rd_valid} !== {1'b0, 8'h00, 1'b0}) begin errors++; $display("FAIL mid_reset_rd: got valid=%b data=%h fvalid=%b expected 0/00/0", s_rd_valid, s_rd_data, f_rd_valid); end
        wr_en = 1'b1; wr_data = 8'h99;
        tick();
        wr_en = 1'b0;
        checks++; if ({f_rd_data, s_level} !== {8'h99, 4'd1}) begin errors++; $display("FAIL post_reset_wr: got fdata=%h level=%0d expected 99/1", f_rd_data, s_level); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++; if ({s_rd_valid, s_rd_data} !== {1'b1, 8'h99}) begin errors++; $display("FAIL post_reset_rd: got valid=%b data=%h expected 1/99", s_rd_valid, s_rd_data); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_empty_rd();
        test_fwft();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
